// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - host write bus and display-side outputs of the scan controller
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [4:0]            wr_code;
  logic                  enable;
  logic [4:0]            code;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  frame_done;

  // Host side: drives the code buffer and the scan enable, observes the display outputs
  modport master (
    output wr_en, wr_addr, wr_code, enable,
    input  code, digit_en, frame_done
  );

  // Controller side
  modport slave (
    input  wr_en, wr_addr, wr_code, enable,
    output code, digit_en, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexes one 5-bit segment code across NUM_DIGITS digits with blanking
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  display_scan_ctrl_if.slave bus
);
  localparam int AW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                  fd_q, fd_d;
  logic [4:0]            buf_q [NUM_DIGITS];

  logic [AW-1:0]         idx_next;
  logic [4:0]            next_code;

  // Next digit position, wrapping after the last digit
  always_comb begin
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Buffer entry for the next digit; read before this edge's write lands, so old data is loaded
  always_comb begin
    next_code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == AW'(i)) next_code = buf_q[i];
    end
  end

  // Scan sequencer: enable low forces idle from any state; digit_en is set only while showing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    den_d   = den_q;
    fd_d    = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      den_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          code_d  = buf_q[0];
          den_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            den_d   = NUM_DIGITS'(1) << idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = idx_next;
            code_d  = next_code;
            den_d   = '0;
            fd_d    = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          den_d   = '0;
        end
      endcase
    end
  end

  // Sequencer and output registers; reset blanks the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      den_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      den_q   <= den_d;
      fd_q    <= fd_d;
    end
  end

  // Per-digit code buffer; writes to addresses past the last digit match no entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.wr_en && (bus.wr_addr == AW'(i))) buf_q[i] <= bus.wr_code;
      end
    end
  end

  assign bus.code       = code_q;
  assign bus.digit_en   = den_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized model-checked bench for display_scan_ctrl (4- and 3-digit)
module tb_display_scan_ctrl;
  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) b4 ();
  display_scan_ctrl_if #(.NUM_DIGITS(3)) b3 ();

  display_scan_ctrl #(.NUM_DIGITS(4), .DWELL(D), .BLANK(B)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );
  display_scan_ctrl #(.NUM_DIGITS(3), .DWELL(D), .BLANK(B)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed edges since scan start give digit and phase by division
  int         m_n [2] = '{4, 3};
  bit         m_run [2];
  int         m_e [2];
  logic [4:0] m_buf [2][4];
  logic [4:0] m_code [2];
  logic [3:0] m_den [2];
  logic       m_fd [2];

  task automatic model_reset(input int id);
    m_run[id]  = 1'b0;
    m_e[id]    = 0;
    m_code[id] = '0;
    m_den[id]  = '0;
    m_fd[id]   = 1'b0;
    for (int k = 0; k < 4; k++) m_buf[id][k] = '0;
  endtask

  task automatic model_step(input int id, input logic en, input logic we, input int wa,
                            input logic [4:0] wc);
    int pos;
    int dig;
    if (!en) begin
      m_run[id] = 1'b0;
      m_e[id]   = 0;
      m_den[id] = '0;
      m_fd[id]  = 1'b0;
    end else if (!m_run[id]) begin
      m_run[id]  = 1'b1;
      m_e[id]    = 0;
      m_code[id] = m_buf[id][0];
      m_den[id]  = '0;
      m_fd[id]   = 1'b0;
    end else begin
      m_e[id]++;
      pos = m_e[id] % P;
      dig = (m_e[id] / P) % m_n[id];
      m_fd[id] = (pos == 0) && (dig == 0);
      if (pos == 0) m_code[id] = m_buf[id][dig];
      m_den[id] = (pos >= B) ? 4'(1 << dig) : 4'd0;
    end
    if (we && wa < m_n[id]) m_buf[id][wa] = wc;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, b4.enable, b4.wr_en, int'(b4.wr_addr), b4.wr_code);
      model_step(1, b3.enable, b3.wr_en, int'(b3.wr_addr), b3.wr_code);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("code4", 32'(b4.code), 32'(m_code[0]));
    chk("den4", 32'(b4.digit_en), 32'(m_den[0]));
    chk("fd4", 32'(b4.frame_done), 32'(m_fd[0]));
    chk("code3", 32'(b3.code), 32'(m_code[1]));
    chk("den3", 32'(b3.digit_en), 32'(m_den[1]));
    chk("fd3", 32'(b3.frame_done), 32'(m_fd[1]));
  end

  task automatic wr4(input int a, input logic [4:0] c);
    b4.wr_en   = 1'b1;
    b4.wr_addr = 2'(a);
    b4.wr_code = c;
    @(negedge clk);
    b4.wr_en   = 1'b0;
  endtask

  task automatic wr3(input int a, input logic [4:0] c);
    b3.wr_en   = 1'b1;
    b3.wr_addr = 2'(a);
    b3.wr_code = c;
    @(negedge clk);
    b3.wr_en   = 1'b0;
  endtask

  task automatic wait_den4(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (b4.digit_en !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b4.digit_en !== v) begin
      errors++;
      $display("FAIL %s timeout: digit_en %b required %b", name, b4.digit_en, v);
    end
  endtask

  function automatic logic fd_of(input int id);
    return (id == 1) ? b3.frame_done : b4.frame_done;
  endfunction

  task automatic fd_gap(input int id, output int gap);
    int n;
    n = 0;
    while (!fd_of(id) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    gap = 1;
    while (!fd_of(id) && gap < 200) begin
      @(negedge clk);
      gap++;
    end
  endtask

  logic [4:0] rec_code [1:25];
  logic [3:0] rec_den [1:25];
  logic       rec_fd [1:25];

  initial begin
    int g;
    int nv;
    logic [2:0] prev3;
    logic [2:0] visits [4];

    b4.wr_en = 1'b0; b4.wr_addr = '0; b4.wr_code = '0; b4.enable = 1'b0;
    b3.wr_en = 1'b0; b3.wr_addr = '0; b3.wr_code = '0; b3.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_code", 32'(b4.code), 32'h0);
    chk("rst_den", 32'(b4.digit_en), 32'h0);
    chk("rst_fd", 32'(b4.frame_done), 32'h0);
    @(negedge clk);

    // Basic scan order and timing
    wr4(0, 5'b10111);
    wr4(1, 5'b11010);
    wr4(2, 5'b01001);
    wr4(3, 5'b00010);
    b4.enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      rec_code[k] = b4.code;
      rec_den[k]  = b4.digit_en;
      rec_fd[k]   = b4.frame_done;
    end
    chk("t1_code1", 32'(rec_code[1]), 32'h17);
    chk("t1_den1", 32'(rec_den[1]), 32'h0);
    chk("t1_den2", 32'(rec_den[2]), 32'h0);
    chk("t1_den3", 32'(rec_den[3]), 32'h1);
    chk("t1_den6", 32'(rec_den[6]), 32'h1);
    chk("t1_den7", 32'(rec_den[7]), 32'h0);
    chk("t1_code7", 32'(rec_code[7]), 32'h1a);
    chk("t1_den9", 32'(rec_den[9]), 32'h2);
    chk("t1_code13", 32'(rec_code[13]), 32'h09);
    chk("t1_den15", 32'(rec_den[15]), 32'h4);
    chk("t1_code19", 32'(rec_code[19]), 32'h02);
    chk("t1_den21", 32'(rec_den[21]), 32'h8);
    chk("t1_den24", 32'(rec_den[24]), 32'h8);
    chk("t1_fd24", 32'(rec_fd[24]), 32'h0);
    chk("t1_fd25", 32'(rec_fd[25]), 32'h1);
    chk("t1_den25", 32'(rec_den[25]), 32'h0);

    // Frame period over free-running frames
    for (int f = 0; f < 3; f++) begin
      fd_gap(0, g);
      chk("t2_frame_gap", 32'(g), 32'd24);
    end

    // Write to the digit being shown takes effect next visit
    wait_den4(4'b0001, "t3_wait0");
    wait_den4(4'b0010, "t3_wait1");
    wr4(1, 5'b11111);
    chk("t3_code_hold", 32'(b4.code), 32'h1a);
    wait_den4(4'b0001, "t3_wait0b");
    wait_den4(4'b0010, "t3_wait1b");
    chk("t3_code_new", 32'(b4.code), 32'h1f);
    // Write on the same edge that loads digit 1
    wait_den4(4'b0001, "t3_wait0c");
    repeat (3) @(negedge clk);
    chk("t3_last_show", 32'(b4.digit_en), 32'h1);
    wr4(1, 5'b00101);
    chk("t3_same_edge_old", 32'(b4.code), 32'h1f);
    wait_den4(4'b0001, "t3_wait0d");
    wait_den4(4'b0010, "t3_wait1d");
    chk("t3_same_edge_new", 32'(b4.code), 32'h05);

    // Drop enable mid-show of digit 2, then restart
    wait_den4(4'b0100, "t4_wait2");
    @(negedge clk);
    b4.enable = 1'b0;
    @(negedge clk);
    chk("t4_den_off", 32'(b4.digit_en), 32'h0);
    chk("t4_code_hold", 32'(b4.code), 32'h09);
    repeat (3) @(negedge clk);
    b4.enable = 1'b1;
    @(negedge clk);
    chk("t4_re_blank1", 32'(b4.digit_en), 32'h0);
    @(negedge clk);
    chk("t4_re_blank2", 32'(b4.digit_en), 32'h0);
    @(negedge clk);
    chk("t4_re_den0", 32'(b4.digit_en), 32'h1);
    chk("t4_re_code", 32'(b4.code), 32'h17);

    // Randomized writes and enable drops on both instances
    for (int c = 0; c < 600; c++) begin
      b4.wr_en   = ($urandom % 4) == 0;
      b4.wr_addr = 2'($urandom);
      b4.wr_code = 5'($urandom);
      b4.enable  = ($urandom % 50) != 0;
      b3.wr_en   = ($urandom % 4) == 0;
      b3.wr_addr = 2'($urandom);
      b3.wr_code = 5'($urandom);
      b3.enable  = ($urandom % 50) != 0;
      @(negedge clk);
    end
    b4.wr_en = 1'b0; b3.wr_en = 1'b0; b3.enable = 1'b0;
    b4.enable = 1'b1;

    // Asynchronous reset mid-show
    wr4(0, 5'b10101);
    wait_den4(4'b0001, "t5_wait_show");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_den", 32'(b4.digit_en), 32'h0);
    chk("t5_async_code", 32'(b4.code), 32'h0);
    chk("t5_async_fd", 32'(b4.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (b4.digit_en != 4'b0000) chk("t5_buf_zero", 32'(b4.code), 32'h0);
    end
    chk("t5_code_zero", 32'(b4.code), 32'h0);
    b4.enable = 1'b0;

    // Three-digit instance: out-of-range write, scan order, frame period
    wr3(3, 5'b11111);
    wr3(0, 5'b00001);
    wr3(1, 5'b00010);
    wr3(2, 5'b00100);
    b3.enable = 1'b1;
    nv = 0;
    prev3 = '0;
    for (int k = 0; k < 100 && nv < 4; k++) begin
      @(negedge clk);
      if (prev3 == 3'b000 && b3.digit_en != 3'b000) begin
        visits[nv] = b3.digit_en;
        if (nv == 0) chk("t6_code_first", 32'(b3.code), 32'h01);
        nv++;
      end
      prev3 = b3.digit_en;
    end
    chk("t6_visit_count", 32'(nv), 32'd4);
    chk("t6_visit0", 32'(visits[0]), 32'h1);
    chk("t6_visit1", 32'(visits[1]), 32'h2);
    chk("t6_visit2", 32'(visits[2]), 32'h4);
    chk("t6_visit3", 32'(visits[3]), 32'h1);
    for (int f = 0; f < 2; f++) begin
      fd_gap(1, g);
      chk("t6_frame_gap", 32'(g), 32'd18);
    end
    b3.enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
